// File: rtl/scramble_sequencer.sv
// scramble_sequencer: registers the user's row/col fire selection and, on request,
// replaces it with a burst of pseudo-random legal moves driven by a Galois LFSR.
module scramble_sequencer #(
  parameter int unsigned MOVES = 16,
  parameter int unsigned GAP   = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scramble_start,
  input  logic       user_fire,
  input  logic       user_nrow,
  input  logic [3:0] user_sel,
  input  logic       user_error,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       fire,
  output logic       busy,
  output logic       done,
  output logic [7:0] moves_left
);

  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned CNT_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [LFSR_W-1:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  lfsr, lfsr_nxt;
  logic [CNT_W-1:0]   gap_cnt, gap_nxt;
  logic [3:0]         row_nxt, col_nxt;
  logic               fire_nxt, busy_nxt, done_nxt;
  logic [CNT_W-1:0]   moves_nxt;
  logic [3:0]         rand_onehot;

  // Free-running LFSR step; shifts right with Galois feedback
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
  end

  // LFSR advances every cycle so the scramble depends on press timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_INIT;
    else       lfsr <= lfsr_nxt;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (scramble_start) state_nxt = FIRE;
      FIRE: state_nxt = WAIT;
      WAIT: if (gap_cnt == '0) state_nxt = (moves_left != '0) ? FIRE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; everything is registered below
  always_comb begin
    row_nxt     = row;
    col_nxt     = col;
    fire_nxt    = 1'b0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    moves_nxt   = moves_left;
    gap_nxt     = gap_cnt;
    rand_onehot = 4'b0001 << lfsr[1:0];
    case (state)
      IDLE: begin
        if (scramble_start) begin
          busy_nxt  = 1'b1;
          moves_nxt = CNT_W'(MOVES);
          row_nxt   = '0;
          col_nxt   = '0;
        end else if (user_error) begin
          row_nxt = '0;
          col_nxt = '0;
        end else begin
          row_nxt  = user_nrow ? 4'b0000 : user_sel;
          col_nxt  = user_nrow ? user_sel : 4'b0000;
          fire_nxt = user_fire;
        end
      end
      FIRE: begin
        row_nxt   = lfsr[2] ? 4'b0000 : rand_onehot;
        col_nxt   = lfsr[2] ? rand_onehot : 4'b0000;
        fire_nxt  = 1'b1;
        moves_nxt = moves_left - CNT_W'(1);
        gap_nxt   = CNT_W'(GAP - 1);
      end
      WAIT: begin
        if (gap_cnt != '0) gap_nxt = gap_cnt - CNT_W'(1);
      end
      DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
        row_nxt  = '0;
        col_nxt  = '0;
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      fire       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      moves_left <= '0;
      gap_cnt    <= '0;
    end else begin
      row        <= row_nxt;
      col        <= col_nxt;
      fire       <= fire_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      moves_left <= moves_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Self-checking bench for scramble_sequencer with a reference LFSR and pulse scoreboard.
module tb_scramble_sequencer;

  localparam int unsigned MOVES = 4;
  localparam int unsigned GAP   = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int unsigned TOTAL = 1 + MOVES * (GAP + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scramble_start = 1'b0;
  logic       user_fire = 1'b0;
  logic       user_nrow = 1'b0;
  logic [3:0] user_sel = 4'b0000;
  logic       user_error = 1'b0;
  logic [3:0] row, col;
  logic       fire, busy, done;
  logic [7:0] moves_left;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [7:0]  ml;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_lfsr;

  scramble_sequencer #(.MOVES(MOVES), .GAP(GAP), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .scramble_start(scramble_start),
    .user_fire(user_fire), .user_nrow(user_nrow), .user_sel(user_sel),
    .user_error(user_error), .row(row), .col(col), .fire(fire),
    .busy(busy), .done(done), .moves_left(moves_left)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Reference LFSR, reseeded by the same reset
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= ref_step(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({row, col, fire, busy, done, moves_left} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got row=%b col=%b fire=%b busy=%b done=%b ml=%0d, want all 0",
               row, col, fire, busy, done, moves_left);
    end
    reset = 1'b0;
    // Load a nonzero selection, then reset asynchronously mid-cycle
    user_sel = 4'b0010; user_nrow = 1'b0; user_fire = 1'b1;
    @(posedge clk);
    #2;
    user_fire = 1'b0;
    n_checks++;
    if (row !== 4'b0010 || fire !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload: got row=%b fire=%b, want 0010/1", row, fire);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({row, col, fire, busy, done, moves_left} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async: got row=%b col=%b fire=%b busy=%b done=%b ml=%0d, want all 0",
               row, col, fire, busy, done, moves_left);
    end
    user_sel = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    user_sel = 4'b0100; user_nrow = 1'b0; user_fire = 1'b1;
    tick();
    user_fire = 1'b0;
    n_checks++;
    if (row !== 4'b0100 || col !== 4'b0000 || fire !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_row: got row=%b col=%b fire=%b, want 0100/0000/1", row, col, fire);
    end
    tick();
    n_checks++;
    if (fire !== 1'b0 || row !== 4'b0100) begin
      n_fail++;
      $display("FAIL pass_fire_width: got fire=%b row=%b, want 0/0100", fire, row);
    end
    user_nrow = 1'b1; user_fire = 1'b1;
    tick();
    user_fire = 1'b0;
    n_checks++;
    if (row !== 4'b0000 || col !== 4'b0100 || fire !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_col: got row=%b col=%b fire=%b, want 0000/0100/1", row, col, fire);
    end
    user_sel = 4'b0000;
    tick();
    n_checks++;
    if (row !== 4'b0000 || col !== 4'b0000 || fire !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_zero_sel: got row=%b col=%b fire=%b, want 0/0/0", row, col, fire);
    end
  endtask

  task automatic test_error();
    user_sel = 4'b1000; user_nrow = 1'b0; user_fire = 1'b1;
    tick();
    user_fire = 1'b0;
    user_error = 1'b1; user_sel = 4'b0010; user_fire = 1'b1;
    tick();
    user_fire = 1'b0; user_error = 1'b0; user_sel = 4'b0000;
    n_checks++;
    if (row !== 4'b0000 || col !== 4'b0000 || fire !== 1'b0) begin
      n_fail++;
      $display("FAIL error_gate: got row=%b col=%b fire=%b, want 0/0/0", row, col, fire);
    end
    tick();
  endtask

  // Full scramble; with lockout=1 extra start/user pulses are thrown in while busy
  task automatic test_scramble(input bit lockout, input string name);
    logic [15:0] v;
    logic [3:0]  oh, last_row, last_col;
    int unsigned j;
    bit          exp_fire, exp_busy, exp_done;
    exp_t        e, got;
    q.delete();
    v = m_lfsr;
    j = 0;
    for (int k = 0; k < int'(MOVES); k++) begin
      while (j < 1 + k * (GAP + 1)) begin
        v = ref_step(v);
        j++;
      end
      oh = 4'b0001 << v[1:0];
      e.cyc = j;
      e.row = v[2] ? 4'b0000 : oh;
      e.col = v[2] ? oh : 4'b0000;
      e.ml  = 8'(MOVES - 1 - k);
      q.push_back(e);
    end
    user_sel = 4'b0000; user_fire = 1'b0; user_error = 1'b0;
    scramble_start = 1'b1;
    last_row = 4'b0000; last_col = 4'b0000;
    for (int unsigned c = 0; c <= TOTAL + 1; c++) begin
      tick();
      scramble_start = 1'b0;
      user_fire = 1'b0;
      exp_fire = (c >= 1) && ((c - 1) % (GAP + 1) == 0) && (c <= 1 + (MOVES - 1) * (GAP + 1));
      exp_busy = (c < TOTAL);
      exp_done = (c == TOTAL);
      n_checks++;
      if (fire !== exp_fire || busy !== exp_busy || done !== exp_done) begin
        n_fail++;
        $display("FAIL %s_sched c=%0d: got fire=%b busy=%b done=%b, want %b/%b/%b",
                 name, c, fire, busy, done, exp_fire, exp_busy, exp_done);
      end
      n_checks++;
      if ($countones(row | col) > 1 || (row & col) !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s_onehot c=%0d: got row=%b col=%b, want at most one bit", name, c, row, col);
      end
      if (fire === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_fire c=%0d: got fire with empty scoreboard, want none", name, c);
        end else begin
          got = q.pop_front();
          if (got.cyc != c || row !== got.row || col !== got.col || moves_left !== got.ml) begin
            n_fail++;
            $display("FAIL %s_pulse c=%0d: got row=%b col=%b ml=%0d, want c=%0d row=%b col=%b ml=%0d",
                     name, c, row, col, moves_left, got.cyc, got.row, got.col, got.ml);
          end
        end
        last_row = row; last_col = col;
      end else if (exp_busy) begin
        n_checks++;
        if (row !== last_row || col !== last_col) begin
          n_fail++;
          $display("FAIL %s_hold c=%0d: got row=%b col=%b, want %b/%b", name, c, row, col, last_row, last_col);
        end
      end else begin
        n_checks++;
        if (row !== 4'b0000 || col !== 4'b0000) begin
          n_fail++;
          $display("FAIL %s_idle_bus c=%0d: got row=%b col=%b, want 0/0", name, c, row, col);
        end
      end
      if (lockout && c >= 1 && c + 1 <= TOTAL) begin
        user_sel = 4'b1000; user_nrow = c[0];
        user_fire = c[0];
        scramble_start = (c == 3) || (c == 6) || (c + 1 == TOTAL);
      end else begin
        user_sel = 4'b0000;
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: got %0d pulses left unissued, want 0", name, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int fires = 0;
    int cyc = 0;
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    while (fires < 2 && cyc < 50) begin
      if (fire === 1'b1) fires++;
      if (fires < 2) begin
        tick();
        cyc++;
      end
    end
    n_checks++;
    if (fires < 2) begin
      n_fail++;
      $display("FAIL mid_wait: got %0d pulses in %0d cycles, want 2", fires, cyc);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({row, col, fire, busy, done, moves_left} !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got row=%b col=%b fire=%b busy=%b done=%b ml=%0d, want all 0",
               row, col, fire, busy, done, moves_left);
    end
    @(negedge clk);
    reset = 1'b0;
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire === 1'b1 || busy === 1'b1 || done === 1'b1) fires++;
    end
    n_checks++;
    if (fires != 0) begin
      n_fail++;
      $display("FAIL mid_quiet: got %0d active cycles after reset, want 0", fires);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_error();
    test_scramble(1'b0, "scramble");
    test_scramble(1'b1, "lockout");
    test_passthrough();
    test_reset_mid();
    test_scramble(1'b0, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
